mtr_drv: RTL and testbench

- Downstream of the PID controller.
- Converts the signed 11-bit wheel speed commands (lft_spd, rght_spd) into complementary, non-overlapping PWM pairs for the left and right H-bridges.
- Each side is one instance of a shared PWM generator with dead-time insertion.
- Duty is updated only at PWM period boundaries so a speed change mid-period cannot produce a runt pulse.

---
 rtl/mtr_pkg.sv | 37 +++
 rtl/pwm_nonovr.sv | 64 ++++++
 rtl/mtr_drv.sv | 58 +++++
 tb/tb_mtr_drv.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mtr_pkg.sv
// Shared types and helpers for the motor PWM driver.
// Build option: define MTR_DUTY_CLAMP_EN to clamp mapped duty away from the
// extremes so that neither output pulse is fully consumed by dead-time.
package mtr_pkg;

  typedef logic signed [10:0] spd_t;
  typedef logic        [10:0] duty_t;

  localparam int unsigned PWM_PERIOD = 2048;
  localparam duty_t       DUTY_ZERO  = 11'h400;

`ifdef MTR_DUTY_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  // Offset-binary mapping (flipping the MSB equals adding 0x400 mod 2048),
  // optionally clamped to [2*nonovr, PWM_PERIOD-1-2*nonovr].
  function automatic duty_t spd2duty(input spd_t spd, input int unsigned nonovr);
    duty_t       d;
    int unsigned lo;
    int unsigned hi;
    d  = duty_t'(spd) ^ DUTY_ZERO;
    lo = 2 * nonovr;
    hi = (PWM_PERIOD - 1) - lo;
    if (CLAMP_EN) begin
      if (32'(d) < lo) begin
        d = duty_t'(lo);
      end else if (32'(d) > hi) begin
        d = duty_t'(hi);
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/pwm_nonovr.sv
// One PWM side: duty shadow loaded at period end, raw compare against the
// shared counter, and dead-time insertion producing a non-overlapping pair.
import mtr_pkg::*;

module pwm_nonovr #(
  parameter int unsigned NONOVERLAP = 32
) (
  input  logic  i_clk,
  input  logic  i_rst,
  input  duty_t i_cnt,
  input  spd_t  i_spd,
  output logic  o_pwm1,
  output logic  o_pwm2
);

  localparam logic [7:0] DEAD_LD = 8'(NONOVERLAP);
  localparam duty_t      CNT_END = duty_t'(PWM_PERIOD - 1);

  duty_t      r_duty;
  logic       r_raw_q;
  logic [7:0] r_dead;
  logic       r_pwm1;
  logic       r_pwm2;

  logic       w_raw;
  logic [7:0] w_dead_nxt;
  logic       w_live;

  // Raw compare and next dead-time count; any raw edge restarts the dead window.
  always_comb begin
    w_raw      = (i_cnt < r_duty);
    w_dead_nxt = '0;
    if (w_raw != r_raw_q) begin
      w_dead_nxt = DEAD_LD;
    end else if (r_dead != '0) begin
      w_dead_nxt = r_dead - 8'd1;
    end
    w_live = (w_dead_nxt == '0);
  end

  // Outputs are registered from the next dead count so PWM1 == raw_q and
  // PWM2 == ~raw_q exactly in cycles where dead_cnt is 0, both low otherwise.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_duty  <= DUTY_ZERO;
      r_raw_q <= 1'b0;
      r_dead  <= DEAD_LD;
      r_pwm1  <= 1'b0;
      r_pwm2  <= 1'b0;
    end else begin
      if (i_cnt == CNT_END) begin
        r_duty <= spd2duty(i_spd, NONOVERLAP);
      end
      r_raw_q <= w_raw;
      r_dead  <= w_dead_nxt;
      r_pwm1  <= w_live & w_raw;
      r_pwm2  <= w_live & ~w_raw;
    end
  end

  assign o_pwm1 = r_pwm1;
  assign o_pwm2 = r_pwm2;

endmodule

// File: rtl/mtr_drv.sv
// Motor driver top: shared free-running period counter plus one
// dead-time PWM generator per wheel.
// Build option: MTR_DUTY_CLAMP_EN (see mtr_pkg) clamps the duty range.
import mtr_pkg::*;

module mtr_drv #(
  parameter int unsigned NONOVERLAP = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic signed [10:0] lft_spd,
  input  logic signed [10:0] rght_spd,
  output logic        lftPWM1,
  output logic        lftPWM2,
  output logic        rghtPWM1,
  output logic        rghtPWM2,
  output logic        period_strt
);

  duty_t r_cnt;
  logic  w_pstrt;

  // Free-running period counter, wraps naturally at PWM_PERIOD.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 11'd1;
    end
  end

  // Masked by rst so the marker stays low while held in reset even though
  // the counter already sits at 0.
  always_comb begin
    w_pstrt = (r_cnt == '0) & ~rst;
  end

  assign period_strt = w_pstrt;

  pwm_nonovr #(.NONOVERLAP(NONOVERLAP)) u_lft (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_cnt  (r_cnt),
    .i_spd  (lft_spd),
    .o_pwm1 (lftPWM1),
    .o_pwm2 (lftPWM2)
  );

  pwm_nonovr #(.NONOVERLAP(NONOVERLAP)) u_rght (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_cnt  (r_cnt),
    .i_spd  (rght_spd),
    .o_pwm1 (rghtPWM1),
    .o_pwm2 (rghtPWM2)
  );

endmodule

// File: tb/tb_mtr_drv.sv
// Directed bench for mtr_drv with NONOVERLAP = 32.
// Honours MTR_DUTY_CLAMP_EN for the clamp scenario.
module tb_mtr_drv;

  logic              clk = 1'b0;
  logic              rst;
  logic signed [10:0] lft_spd;
  logic signed [10:0] rght_spd;
  logic              lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, period_strt;

  int n_cmp  = 0;
  int n_fail = 0;

  logic pl1 = 1'b0, pl2 = 1'b0, pr1 = 1'b0, pr2 = 1'b0;
  int   run_l = 0, run_r = 0;

  always #5 clk = ~clk;

  mtr_drv #(.NONOVERLAP(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .lft_spd     (lft_spd),
    .rght_spd    (rght_spd),
    .lftPWM1     (lftPWM1),
    .lftPWM2     (lftPWM2),
    .rghtPWM1    (rghtPWM1),
    .rghtPWM2    (rghtPWM2),
    .period_strt (period_strt)
  );

  // Advance one cycle, sample at negedge, and check overlap / dead-time invariants.
  task automatic tick();
    @(negedge clk);
    n_cmp++;
    if ((lftPWM1 & lftPWM2) === 1'b1 || (rghtPWM1 & rghtPWM2) === 1'b1) begin
      n_fail++;
      $display("FAIL overlap: l=%b%b r=%b%b, required no pair both high", lftPWM1, lftPWM2, rghtPWM1, rghtPWM2);
    end
    if ((lftPWM1 & ~pl1) === 1'b1 || (lftPWM2 & ~pl2) === 1'b1) begin
      n_cmp++;
      if (run_l < 32) begin
        n_fail++;
        $display("FAIL dead_left: both-low run %0d before switch, required >= 32", run_l);
      end
    end
    if ((rghtPWM1 & ~pr1) === 1'b1 || (rghtPWM2 & ~pr2) === 1'b1) begin
      n_cmp++;
      if (run_r < 32) begin
        n_fail++;
        $display("FAIL dead_right: both-low run %0d before switch, required >= 32", run_r);
      end
    end
    run_l = (lftPWM1 === 1'b0 && lftPWM2 === 1'b0) ? run_l + 1 : 0;
    run_r = (rghtPWM1 === 1'b0 && rghtPWM2 === 1'b0) ? run_r + 1 : 0;
    pl1 = lftPWM1; pl2 = lftPWM2; pr1 = rghtPWM1; pr2 = rghtPWM2;
  endtask

  task automatic wait_pstrt();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 4096 && !seen; k++) begin
      tick();
      if (period_strt === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_fail++;
      $display("FAIL wait_pstrt: period_strt not seen in 4096 cycles, required a pulse");
    end
  endtask

  // Call with the current sample at cnt == 0; returns at the cnt == 2047 sample.
  task automatic count_period(output int l1, output int l2, output int r1, output int r2);
    l1 = 0; l2 = 0; r1 = 0; r2 = 0;
    for (int i = 0; i < 2048; i++) begin
      if (i != 0) tick();
      l1 += int'(lftPWM1); l2 += int'(lftPWM2);
      r1 += int'(rghtPWM1); r2 += int'(rghtPWM2);
    end
  endtask

  task automatic test_reset();
    logic e1;
    rst = 1'b1; lft_spd = '0; rght_spd = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if ({lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, period_strt} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_hold: outs=%b, required 00000", {lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, period_strt});
      end
    end
    rst = 1'b0;
    #1;
    for (int c = 0; c <= 40; c++) begin
      if (c != 0) tick();
      e1 = (c >= 33);
      n_cmp++;
      if ({lftPWM1, lftPWM2, rghtPWM1, rghtPWM2} !== {e1, 1'b0, e1, 1'b0} || period_strt !== (c == 0)) begin
        n_fail++;
        $display("FAIL release c=%0d: pwm=%b pstrt=%b, required pwm=%b pstrt=%b", c,
                 {lftPWM1, lftPWM2, rghtPWM1, rghtPWM2}, period_strt, {e1, 1'b0, e1, 1'b0}, (c == 0));
      end
    end
  endtask

  task automatic test_steady();
    int l1, l2, r1, r2;
    wait_pstrt();
    count_period(l1, l2, r1, r2);
    n_cmp++;
    if (l1 !== 992 || l2 !== 992) begin
      n_fail++; $display("FAIL steady_left: hi1=%0d hi2=%0d, required 992/992", l1, l2);
    end
    n_cmp++;
    if (r1 !== 992 || r2 !== 992) begin
      n_fail++; $display("FAIL steady_right: hi1=%0d hi2=%0d, required 992/992", r1, r2);
    end
  endtask

  task automatic test_forward();
    int l1, l2, r1, r2;
    lft_spd = 11'sd1023;
    wait_pstrt();
    count_period(l1, l2, r1, r2);
    n_cmp++;
    if (l1 !== 2015) begin
      n_fail++; $display("FAIL fwd_first: hi1=%0d, required 2015", l1);
    end
    wait_pstrt();
    count_period(l1, l2, r1, r2);
    n_cmp++;
    if (l1 !== 2015 || l2 !== 0) begin
      n_fail++; $display("FAIL fwd_steady: hi1=%0d hi2=%0d, required 2015/0", l1, l2);
    end
    n_cmp++;
    if (r1 !== 992 || r2 !== 992) begin
      n_fail++; $display("FAIL fwd_right_indep: hi1=%0d hi2=%0d, required 992/992", r1, r2);
    end
  endtask

  task automatic test_reverse();
    int l1, l2, r1, r2;
    lft_spd = -11'sd512; rght_spd = 11'sd256;
    wait_pstrt();
    count_period(l1, l2, r1, r2);
    n_cmp++;
    if (l1 !== 480 || r1 !== 1248) begin
      n_fail++; $display("FAIL rev_first: l1=%0d r1=%0d, required 480/1248", l1, r1);
    end
    wait_pstrt();
    count_period(l1, l2, r1, r2);
    n_cmp++;
    if (l1 !== 480 || l2 !== 1504) begin
      n_fail++; $display("FAIL rev_left: hi1=%0d hi2=%0d, required 480/1504", l1, l2);
    end
    n_cmp++;
    if (r1 !== 1248 || r2 !== 736) begin
      n_fail++; $display("FAIL rev_right: hi1=%0d hi2=%0d, required 1248/736", r1, r2);
    end
  endtask

  task automatic test_mid_update();
    int l1, l2, r1, r2;
    lft_spd = '0; rght_spd = '0;
    wait_pstrt();
    l1 = 0; l2 = 0;
    for (int i = 0; i < 2048; i++) begin
      if (i != 0) tick();
      l1 += int'(lftPWM1); l2 += int'(lftPWM2);
      if (i == 500) lft_spd = 11'sd512;
    end
    n_cmp++;
    if (l1 !== 992 || l2 !== 992) begin
      n_fail++; $display("FAIL mid_hold: hi1=%0d hi2=%0d, required 992/992", l1, l2);
    end
    wait_pstrt();
    count_period(l1, l2, r1, r2);
    n_cmp++;
    if (l1 !== 1504 || l2 !== 480) begin
      n_fail++; $display("FAIL mid_apply: hi1=%0d hi2=%0d, required 1504/480", l1, l2);
    end
  endtask

  task automatic test_random();
    for (int p = 0; p < 16; p++) begin
      wait_pstrt();
      lft_spd  = 11'($urandom_range(0, 2047));
      rght_spd = 11'($urandom_range(0, 2047));
      for (int i = 0; i < 2047; i++) tick();
    end
  endtask

  task automatic test_clamp();
    int l1, l2, r1, r2;
    lft_spd = 11'h400; rght_spd = 11'sd1023;
    wait_pstrt();
    count_period(l1, l2, r1, r2);
    wait_pstrt();
    count_period(l1, l2, r1, r2);
`ifdef MTR_DUTY_CLAMP_EN
    n_cmp++;
    if (l1 !== 32 || l2 !== 1952) begin
      n_fail++; $display("FAIL clamp_low: hi1=%0d hi2=%0d, required 32/1952", l1, l2);
    end
    n_cmp++;
    if (r1 !== 1951 || r2 !== 33) begin
      n_fail++; $display("FAIL clamp_high: hi1=%0d hi2=%0d, required 1951/33", r1, r2);
    end
`else
    n_cmp++;
    if (l1 !== 0 || l2 !== 2048) begin
      n_fail++; $display("FAIL noclamp_low: hi1=%0d hi2=%0d, required 0/2048", l1, l2);
    end
    n_cmp++;
    if (r1 !== 2015 || r2 !== 0) begin
      n_fail++; $display("FAIL noclamp_high: hi1=%0d hi2=%0d, required 2015/0", r1, r2);
    end
`endif
  endtask

  task automatic test_reset_mid();
    lft_spd = '0; rght_spd = '0;
    wait_pstrt();
    wait_pstrt();
    for (int i = 0; i < 200; i++) tick();
    n_cmp++;
    if (lftPWM1 !== 1'b1 || rghtPWM1 !== 1'b1) begin
      n_fail++; $display("FAIL rmid_pre: l1=%b r1=%b, required 1/1", lftPWM1, rghtPWM1);
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, period_strt} !== 5'b0) begin
        n_fail++;
        $display("FAIL rmid_hold %0d: outs=%b, required 00000", i, {lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, period_strt});
      end
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (period_strt !== 1'b1 || {lftPWM1, lftPWM2, rghtPWM1, rghtPWM2} !== 4'b0) begin
      n_fail++; $display("FAIL rmid_release: pstrt=%b pwm=%b, required 1/0000", period_strt, {lftPWM1, lftPWM2, rghtPWM1, rghtPWM2});
    end
    for (int i = 0; i < 32; i++) tick();
    n_cmp++;
    if (lftPWM1 !== 1'b0) begin
      n_fail++; $display("FAIL rmid_c32: l1=%b, required 0", lftPWM1);
    end
    tick();
    n_cmp++;
    if (lftPWM1 !== 1'b1 || lftPWM2 !== 1'b0) begin
      n_fail++; $display("FAIL rmid_c33: l=%b%b, required 10", lftPWM1, lftPWM2);
    end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_forward();
    test_reverse();
    test_mid_update();
    test_random();
    test_clamp();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
